cordic_vector_iter: RTL and testbench



---
 rtl/cordic_pkg.sv | 42 ++++
 rtl/cordic_vec_step.sv | 42 ++++
 rtl/cordic_vector_iter.sv | 127 ++++++++++++
 tb/tb_cordic_vector_iter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC subsystem: FSM states, the arctangent table
// generator and the quadrant pre-rotation angle, all parameterised by angle width.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_DONE
    } state_e;

    // atan(1/n) in Q60 via its alternating Taylor series; only ever evaluated at elaboration.
    function automatic longint unsigned atan_inv_q60(input longint unsigned n);
        longint unsigned p;
        longint unsigned acc_pos;
        longint unsigned acc_neg;
        p       = (64'd1 << 60) / n;
        acc_pos = 64'd0;
        acc_neg = 64'd0;
        for (int k = 0; k < 40; k++) begin
            if ((k % 2) == 0) acc_pos += p / 64'(2 * k + 1);
            else              acc_neg += p / 64'(2 * k + 1);
            p = p / n;
            p = p / n;
        end
        return acc_pos - acc_neg;
    endfunction

    // round(atan(2^-i) * 2^(w-1) / pi), using pi/4 = 4*atan(1/5) - atan(1/239).
    function automatic longint unsigned atan_lsb(input int i, input int w);
        longint unsigned quarter;
        longint unsigned t;
        quarter = (64'd4 * atan_inv_q60(64'd5) - atan_inv_q60(64'd239)) >> 24;
        if (i == 0) return 64'd1 << (w - 3);
        t = atan_inv_q60(64'd1 << i) >> 24;
        return ((t << (w - 3)) + (quarter >> 1)) / quarter;
    endfunction

    function automatic longint unsigned quad_angle(input int w);
        return 64'd1 << (w - 2);
    endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// One vectoring micro-rotation: steers on the sign of Y, shifts by the step index,
// and accumulates the matching arctangent into Z.
module cordic_vec_step
    import cordic_pkg::*;
#(
    parameter int XW = 18,
    parameter int ZW = 16,
    parameter int SW = 4
) (
    input  logic signed [XW-1:0] x_in,
    input  logic signed [XW-1:0] y_in,
    input  logic        [ZW-1:0] z_in,
    input  logic        [SW-1:0] shift,
    output logic signed [XW-1:0] x_out,
    output logic signed [XW-1:0] y_out,
    output logic        [ZW-1:0] z_out
);

    logic [ZW-1:0] atan_tab [2**SW];

    for (genvar g = 0; g < 2**SW; g++) begin : g_atan
        assign atan_tab[g] = ZW'(atan_lsb(g, ZW));
    end

    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;

    always_comb begin
        x_sh = x_in >>> shift;
        y_sh = y_in >>> shift;
        if (!y_in[XW-1]) begin
            x_out = x_in + y_sh;
            y_out = y_in - x_sh;
            z_out = z_in + atan_tab[shift];
        end else begin
            x_out = x_in - y_sh;
            y_out = y_in + x_sh;
            z_out = z_in - atan_tab[shift];
        end
    end

endmodule

// File: rtl/cordic_vector_iter.sv
// Iterative vectoring CORDIC: one shared micro-rotation reused ITER times to
// recover magnitude (K-scaled) and binary angle, with valid/ready on both sides.
//
// state   | meaning
// ST_IDLE | waiting for an operand, in_ready high
// ST_ITER | stepping micro-rotations, then one edge to latch the result
// ST_DONE | result held, out_valid high until out_ready
module cordic_vector_iter
    import cordic_pkg::*;
#(
    parameter int W    = 16,
    parameter int ITER = 14
) (
    input  logic         C,
    input  logic         RST_N,
    input  logic         CE,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] X_in,
    input  logic [W-1:0] Y_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W+1:0] mag,
    output logic [W-1:0] angle
);

    localparam int XW = W + 2;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] Z_QUAD_POS = W'(quad_angle(W));
    localparam logic [W-1:0] Z_QUAD_NEG = W'(64'd0 - quad_angle(W));

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic signed [XW-1:0] x_ext, y_ext, x_step, y_step;
    logic [W-1:0]         z_q, z_d, z_step;
    logic [W-1:0]         angle_q, angle_d;
    logic [XW-1:0]        mag_q, mag_d;

    cordic_vec_step #(.XW(XW), .ZW(W), .SW(CW)) u_step (
        .x_in  (x_q),
        .y_in  (y_q),
        .z_in  (z_q),
        .shift (cnt_q),
        .x_out (x_step),
        .y_out (y_step),
        .z_out (z_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        mag_d   = mag_q;
        angle_d = angle_q;
        x_ext   = {{2{X_in[W-1]}}, X_in};
        y_ext   = {{2{Y_in[W-1]}}, Y_in};
        case (state_q)
            ST_IDLE: begin
                if (CE && in_valid) begin
                    cnt_d   = '0;
                    state_d = ST_ITER;
                    // Pre-rotate left-half-plane vectors by +/-90 deg so X starts non-negative.
                    if (!X_in[W-1]) begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end else if (!Y_in[W-1]) begin
                        x_d = y_ext;
                        y_d = -x_ext;
                        z_d = Z_QUAD_POS;
                    end else begin
                        x_d = -y_ext;
                        y_d = x_ext;
                        z_d = Z_QUAD_NEG;
                    end
                end
            end
            ST_ITER: begin
                if (CE) begin
                    if (cnt_q == CW'(ITER)) begin
                        mag_d   = x_q;
                        angle_d = z_q;
                        state_d = ST_DONE;
                    end else begin
                        x_d   = x_step;
                        y_d   = y_step;
                        z_d   = z_step;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (CE && out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge C or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            mag_q   <= '0;
            angle_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            mag_q   <= mag_d;
            angle_q <= angle_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign mag       = mag_q;
    assign angle     = angle_q;

endmodule

// File: tb/tb_cordic_vector_iter.sv
// Bench for cordic_vector_iter: edge-counting handshake model plus real-valued
// atan2/hypot reference, checked every cycle, with directed and random operands.
module tb_cordic_vector_iter;

    localparam int  W    = 16;
    localparam int  ITER = 14;
    localparam real K    = 1.6467602581210656;
    localparam real PI   = 3.14159265358979323846;
    localparam real HALF = 32768.0;

    logic                C         = 1'b0;
    logic                RST_N     = 1'b0;
    logic                CE        = 1'b1;
    logic                in_valid  = 1'b0;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] X_in      = '0;
    logic signed [W-1:0] Y_in      = '0;
    logic                in_ready;
    logic                out_valid;
    logic [W+1:0]        mag;
    logic [W-1:0]        angle;

    int n_cmp  = 0;
    int n_bad  = 0;
    bit chk_en = 1'b0;

    cordic_vector_iter #(.W(W), .ITER(ITER)) dut (
        .C         (C),
        .RST_N     (RST_N),
        .CE        (CE),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X_in      (X_in),
        .Y_in      (Y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag       (mag),
        .angle     (angle)
    );

    always #5 C = ~C;

    function automatic real exp_mag(input real x, input real y);
        return K * $sqrt(x * x + y * y);
    endfunction

    function automatic real exp_ang(input real x, input real y);
        return $atan2(y, x) * HALF / PI;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input real act, input real exp, input real tol);
        n_cmp++;
        if (act - exp > tol || exp - act > tol) begin
            n_bad++;
            $display("FAIL %s: got %0.2f want %0.2f +/- %0.2f at %0t", name, act, exp, tol, $time);
        end
    endtask

    task automatic check_angle(input string name, input logic [W-1:0] a, input real exp, input real tol);
        real d;
        d = real'($signed(a)) - exp;
        while (d > HALF)  d -= 2.0 * HALF;
        while (d < -HALF) d += 2.0 * HALF;
        n_cmp++;
        if (d > tol || d < -tol) begin
            n_bad++;
            $display("FAIL %s: got angle %0d want %0.2f +/- %0.1f at %0t", name, $signed(a), exp, tol, $time);
        end
    endtask

    // Reference: 0 = idle, 1 = busy for m_rem more CE edges, 2 = result presented.
    int  m_phase = 0;
    int  m_rem   = 0;
    real m_x     = 0.0;
    real m_y     = 0.0;
    real m_rx    = 0.0;
    real m_ry    = 0.0;
    bit  m_res   = 1'b0;

    always @(posedge C or negedge RST_N) begin
        if (!RST_N) begin
            m_phase <= 0;
            m_rem   <= 0;
            m_res   <= 1'b0;
        end else if (CE) begin
            case (m_phase)
                0: if (in_valid) begin
                    m_phase <= 1;
                    m_rem   <= ITER + 1;
                    m_x     <= real'(X_in);
                    m_y     <= real'(Y_in);
                end
                1: begin
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) begin
                        m_phase <= 2;
                        m_rx    <= m_x;
                        m_ry    <= m_y;
                        m_res   <= 1'b1;
                    end
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge C) begin
        if (chk_en) begin
            check_bit("in_ready", in_ready, m_phase == 0);
            check_bit("out_valid", out_valid, m_phase == 2);
            if (!m_res) begin
                check_near("mag idle", real'(mag), 0.0, 0.0);
                check_near("angle idle", real'(angle), 0.0, 0.0);
            end else if (m_rx == 0.0 && m_ry == 0.0) begin
                check_near("mag zero vec", real'(mag), 0.0, 0.0);
            end else begin
                check_near("mag model", real'(mag), exp_mag(m_rx, m_ry),
                           0.0005 * exp_mag(m_rx, m_ry) + 4.0);
                check_angle("angle model", angle, exp_ang(m_rx, m_ry), 3.0);
            end
        end
    end

    // Called at posedge+2 with the DUT idle; returns at posedge+2 with the DUT idle again.
    task automatic do_op(input int x, input int y, input int ce_at, input int ce_len,
                         input int hold, input bit poke,
                         output int lat, output logic [W+1:0] m, output logic [W-1:0] a);
        int n;
        bit seen;
        X_in     = W'(x);
        Y_in     = W'(y);
        in_valid = 1'b1;
        @(posedge C);
        #2;
        in_valid = 1'b0;
        X_in     = W'($urandom);
        Y_in     = W'($urandom);
        n        = 0;
        seen     = 1'b0;
        while (!seen && n < 60) begin
            @(posedge C);
            n++;
            #2;
            if (ce_len > 0) CE = !(n >= ce_at && n < ce_at + ce_len);
            @(negedge C);
            seen = out_valid;
        end
        CE = 1'b1;
        check_bit("result timeout", seen, 1'b1);
        lat = n;
        m   = mag;
        a   = angle;
        for (int h = 0; h < hold; h++) begin
            @(posedge C);
            #2;
            if (poke) begin
                in_valid = 1'b1;
                X_in     = W'($urandom);
                Y_in     = W'($urandom);
            end
            @(negedge C);
            check_bit("hold out_valid", out_valid, 1'b1);
            check_bit("hold in_ready", in_ready, 1'b0);
        end
        @(posedge C);
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge C);
        #2;
        out_ready = 1'b0;
        check_bit("handshake out_valid", out_valid, 1'b0);
        check_bit("handshake in_ready", in_ready, 1'b1);
    endtask

    initial begin
        int lat;
        logic [W+1:0] m;
        logic [W-1:0] a;
        logic [15:0] rx, ry;
        int x, y, hold, tries;

        RST_N = 1'b0;
        repeat (3) @(posedge C);
        #2;
        check_bit("reset in_ready", in_ready, 1'b1);
        check_bit("reset out_valid", out_valid, 1'b0);
        check_near("reset mag", real'(mag), 0.0, 0.0);
        check_near("reset angle", real'(angle), 0.0, 0.0);
        RST_N  = 1'b1;
        chk_en = 1'b1;

        do_op(10000, 0, 0, 0, 0, 1'b0, lat, m, a);
        check_int("latency +x", lat, 15);
        check_near("mag +x", real'(m), 16468.0, 4.0);
        check_angle("angle +x", a, 0.0, 2.0);

        do_op(0, 10000, 0, 0, 0, 1'b0, lat, m, a);
        check_near("mag +y", real'(m), 16468.0, 4.0);
        check_angle("angle +y", a, 16384.0, 2.0);

        do_op(-10000, 0, 0, 0, 0, 1'b0, lat, m, a);
        check_near("mag -x", real'(m), 16468.0, 4.0);
        check_angle("angle -x", a, 32768.0, 2.0);

        do_op(-7071, -7071, 0, 0, 0, 1'b0, lat, m, a);
        check_near("mag q3", real'(m), 16468.0, 6.0);
        check_angle("angle q3", a, -24576.0, 2.0);

        do_op(-32768, -32768, 0, 0, 0, 1'b0, lat, m, a);
        check_near("mag corner", real'(m), 76313.0, 16.0);
        check_angle("angle corner", a, -24576.0, 2.0);

        do_op(3000, -20000, 0, 0, 5, 1'b1, lat, m, a);
        check_int("latency hold", lat, 15);

        do_op(12345, 6789, 5, 3, 0, 1'b0, lat, m, a);
        check_int("latency ce gap", lat, 18);
        check_near("mag ce gap", real'(m), exp_mag(12345.0, 6789.0), 12.0);
        check_angle("angle ce gap", a, exp_ang(12345.0, 6789.0), 3.0);

        X_in     = 16'sd5000;
        Y_in     = 16'sd5000;
        in_valid = 1'b1;
        @(posedge C);
        #2;
        in_valid = 1'b0;
        repeat (6) @(posedge C);
        #2;
        RST_N = 1'b0;
        #1;
        check_bit("mid reset out_valid", out_valid, 1'b0);
        check_bit("mid reset in_ready", in_ready, 1'b1);
        check_near("mid reset mag", real'(mag), 0.0, 0.0);
        check_near("mid reset angle", real'(angle), 0.0, 0.0);
        @(posedge C);
        #2;
        RST_N = 1'b1;
        do_op(-15000, 9000, 0, 0, 0, 1'b0, lat, m, a);
        check_int("latency after reset", lat, 15);
        check_near("mag after reset", real'(m), exp_mag(-15000.0, 9000.0), 13.0);
        check_angle("angle after reset", a, exp_ang(-15000.0, 9000.0), 3.0);

        for (int k = 0; k < 200; k++) begin
            tries = 0;
            do begin
                rx = 16'($urandom);
                ry = 16'($urandom);
                x  = int'($signed(rx));
                y  = int'($signed(ry));
                tries++;
            end while (real'(x) * real'(x) + real'(y) * real'(y) < 16384.0 * 16384.0 && tries < 50);
            hold = int'($urandom_range(0, 3));
            do_op(x, y, 0, 0, hold, 1'b0, lat, m, a);
            check_int("latency random", lat, 15);
            check_near("mag random", real'(m), exp_mag(real'(x), real'(y)),
                       0.0005 * exp_mag(real'(x), real'(y)) + 4.0);
            check_angle("angle random", a, exp_ang(real'(x), real'(y)), 3.0);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
